// File: rtl/bt_cmd_parser.sv
// Frame parser behind the Bluetooth UART receiver: SOF, code, length, payload, XOR checksum.
// Validated commands are held on cmd_* with a valid/ack handshake; errors are one-cycle pulses.
module bt_cmd_parser #(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned TIMEOUT_MS = 10,
    parameter int unsigned MAX_LEN    = 4,
    parameter logic [7:0]  SOF        = 8'hAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        cmd_valid,
    input  logic        cmd_ack,
    output logic [7:0]  cmd_code,
    output logic [2:0]  cmd_len,
    output logic [31:0] cmd_payload,
    output logic        frame_err,
    output logic        timeout_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [31:0] TimeoutLimit = 32'(CLK_FREQ / 1000 * TIMEOUT_MS - 1);
    localparam logic [7:0]  MaxLenByte   = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StCode,
        StLen,
        StPayload,
        StChk,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic        rx_ready_q, rx_ready_d;
    logic [7:0]  chk_q, chk_d;
    logic [31:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  code_q, code_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] payload_q, payload_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic        timeout_err_q, timeout_err_d;
    logic        overrun_q, overrun_d;
    logic        busy_q, busy_d;

    logic        strobe;
    logic        timed;

    always_comb begin
        strobe        = rx_ready & ~rx_ready_q;
        timed         = state_q inside {StCode, StLen, StPayload, StChk};

        state_d       = state_q;
        rx_ready_d    = rx_ready;
        chk_d         = chk_q;
        idx_d         = idx_q;
        code_d        = code_q;
        len_d         = len_q;
        payload_d     = payload_q;
        cmd_valid_d   = cmd_valid_q;
        frame_err_d   = 1'b0;
        timeout_err_d = 1'b0;
        overrun_d     = 1'b0;

        // Counter clears on every byte and idles at zero outside the in-frame states,
        // so every state entry starts from zero.
        if (timed && !strobe) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (strobe && rx_data == SOF) begin
                    state_d = StCode;
                end
            end
            StCode: begin
                if (strobe) begin
                    code_d  = rx_data;
                    chk_d   = rx_data;
                    state_d = StLen;
                end
            end
            StLen: begin
                if (strobe) begin
                    if (rx_data > MaxLenByte) begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        chk_d     = chk_q ^ rx_data;
                        len_d     = rx_data[2:0];
                        payload_d = '0;
                        idx_d     = '0;
                        state_d   = (rx_data == 8'd0) ? StChk : StPayload;
                    end
                end
            end
            StPayload: begin
                if (strobe) begin
                    payload_d[{idx_q, 3'b000} +: 8] = rx_data;
                    chk_d = chk_q ^ rx_data;
                    idx_d = idx_q + 2'd1;
                    if ({1'b0, idx_q} + 3'd1 == len_q) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (strobe) begin
                    if (rx_data == chk_q) begin
                        cmd_valid_d = 1'b1;
                        state_d     = StHold;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StIdle;
                    end
                end
            end
            StHold: begin
                // Any byte arriving while a command is pending is lost, SOF included.
                if (strobe) begin
                    overrun_d = 1'b1;
                end
                if (cmd_valid_q && cmd_ack) begin
                    cmd_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A byte in the terminal-count cycle was handled above and takes precedence.
        if (timed && !strobe && cnt_q == TimeoutLimit) begin
            timeout_err_d = 1'b1;
            state_d       = StIdle;
            cnt_d         = '0;
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            rx_ready_q    <= 1'b0;
            chk_q         <= '0;
            cnt_q         <= '0;
            idx_q         <= '0;
            code_q        <= '0;
            len_q         <= '0;
            payload_q     <= '0;
            cmd_valid_q   <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
            overrun_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ready_q    <= rx_ready_d;
            chk_q         <= chk_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            code_q        <= code_d;
            len_q         <= len_d;
            payload_q     <= payload_d;
            cmd_valid_q   <= cmd_valid_d;
            frame_err_q   <= frame_err_d;
            timeout_err_q <= timeout_err_d;
            overrun_q     <= overrun_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = code_q;
    assign cmd_len     = len_q;
    assign cmd_payload = payload_q;
    assign frame_err   = frame_err_q;
    assign timeout_err = timeout_err_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_bt_cmd_parser.sv
// Scoreboard bench for bt_cmd_parser: expected commands and error pulses are queued as
// stimulus is driven and matched by a monitor as the DUT reports them.
module tb_bt_cmd_parser;

    localparam int EvCmd     = 0;
    localparam int EvFrame   = 1;
    localparam int EvTimeout = 2;
    localparam int EvOverrun = 3;

    typedef struct {
        int          kind;
        logic [7:0]  code;
        logic [2:0]  len;
        logic [31:0] payload;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        cmd_valid;
    logic        cmd_ack;
    logic [7:0]  cmd_code;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_payload;
    logic        frame_err;
    logic        timeout_err;
    logic        overrun;
    logic        busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_valid = 1'b0;
    logic prev_pulse = 1'b0;

    bt_cmd_parser #(
        .CLK_FREQ   (100000),
        .TIMEOUT_MS (1),
        .MAX_LEN    (4),
        .SOF        (8'hAA)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .cmd_valid   (cmd_valid),
        .cmd_ack     (cmd_ack),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .cmd_payload (cmd_payload),
        .frame_err   (frame_err),
        .timeout_err (timeout_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_expect(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_unexpected_event", kind, 32'hFFFF);
            return;
        end
        e = sb.pop_front();
        check_eq("event_kind", kind, e.kind);
        if (kind == EvCmd) begin
            check_eq("cmd_code", cmd_code, e.code);
            check_eq("cmd_len", cmd_len, e.len);
            check_eq("cmd_payload", cmd_payload, e.payload);
        end
    endtask

    task automatic push_event(input int kind);
        exp_t e;
        e = '{kind, 8'h00, 3'd0, 32'h0};
        sb.push_back(e);
    endtask

    task automatic push_cmd(input logic [7:0] code, input logic [2:0] len, input logic [31:0] pl);
        exp_t e;
        e = '{EvCmd, code, len, pl};
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] code, input int unsigned len,
                              input logic [31:0] pl);
        logic [7:0] chk;
        chk = code ^ 8'(len);
        push_cmd(code, 3'(len), pl);
        send_byte(8'hAA);
        send_byte(code);
        send_byte(8'(len));
        for (int i = 0; i < int'(len); i++) begin
            send_byte(pl[8*i +: 8]);
            chk = chk ^ pl[8*i +: 8];
        end
        send_byte(chk);
        check_eq("valid_latency", cmd_valid, 1);
    endtask

    task automatic ack_cmd();
        @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check_eq("valid_drop", cmd_valid, 0);
        check_eq("busy_after_ack", busy, 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, cmd_valid, 0);
        check_eq({tag, "_code"}, cmd_code, 0);
        check_eq({tag, "_len"}, cmd_len, 0);
        check_eq({tag, "_payload"}, cmd_payload, 0);
        check_eq({tag, "_pulses"}, {frame_err, timeout_err, overrun}, 0);
        check_eq({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (cmd_valid && !prev_valid) sb_expect(EvCmd);
            if (frame_err) sb_expect(EvFrame);
            if (timeout_err) sb_expect(EvTimeout);
            if (overrun) sb_expect(EvOverrun);
            if (frame_err || timeout_err || overrun) begin
                check_eq("pulse_exclusive", 32'(frame_err) + 32'(timeout_err) + 32'(overrun), 1);
                check_eq("pulse_width", prev_pulse, 0);
            end
        end
        prev_valid <= cmd_valid;
        prev_pulse <= frame_err | timeout_err | overrun;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        cmd_ack  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Ack with nothing pending is ignored
        @(negedge clk);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        check_eq("idle_ack_valid", cmd_valid, 0);
        check_eq("idle_ack_busy", busy, 0);

        // Valid frame from explicit byte list
        push_cmd(8'h10, 3'd2, 32'h0000_5634);
        send_byte(8'hAA);
        send_byte(8'h10);
        check_eq("busy_in_frame", busy, 1);
        send_byte(8'h02);
        send_byte(8'h34);
        send_byte(8'h56);
        send_byte(8'h70);
        check_eq("valid_latency", cmd_valid, 1);
        repeat (4) @(negedge clk);
        check_eq("hold_valid", cmd_valid, 1);
        check_eq("hold_code", cmd_code, 8'h10);
        check_eq("hold_payload", cmd_payload, 32'h0000_5634);
        ack_cmd();

        // Zero-length frame
        send_frame(8'h05, 0, 32'h0);
        ack_cmd();

        // Bad checksum, then a good frame
        push_event(EvFrame);
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h01);
        send_byte(8'hFF);
        send_byte(8'h00);
        check_eq("badchk_busy", busy, 0);
        check_eq("badchk_valid", cmd_valid, 0);
        send_frame(8'h01, 0, 32'h0);
        ack_cmd();

        // Length above maximum, then restart on next SOF
        push_event(EvFrame);
        send_byte(8'hAA);
        send_byte(8'h22);
        send_byte(8'h05);
        check_eq("badlen_busy", busy, 0);
        send_frame(8'h33, 1, 32'h0000_007E);
        ack_cmd();
        send_frame(8'h44, 4, 32'h0403_0201);
        ack_cmd();

        // Inter-byte timeout: 100 cycles after last strobe
        push_event(EvTimeout);
        send_byte(8'hAA);
        send_byte(8'h10);
        n = 0;
        while (!timeout_err && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_cycles", n, 100);
        check_eq("timeout_busy", busy, 0);

        // Overrun while held; long hold must not time out
        send_frame(8'h5A, 3, 32'h00C0_FFEE);
        repeat (150) @(negedge clk);
        check_eq("long_hold_valid", cmd_valid, 1);
        push_event(EvOverrun);
        send_byte(8'h11);
        check_eq("ovr_valid", cmd_valid, 1);
        check_eq("ovr_code", cmd_code, 8'h5A);
        check_eq("ovr_len", cmd_len, 3);
        check_eq("ovr_payload", cmd_payload, 32'h00C0_FFEE);
        push_event(EvOverrun);
        send_byte(8'hAA);
        check_eq("ovr_sof_busy", busy, 1);
        // Ack and byte in the same cycle
        push_event(EvOverrun);
        @(negedge clk);
        cmd_ack  = 1'b1;
        rx_data  = 8'h22;
        rx_ready = 1'b1;
        @(negedge clk);
        cmd_ack  = 1'b0;
        rx_ready = 1'b0;
        check_eq("ack_strobe_valid", cmd_valid, 0);
        check_eq("ack_strobe_ovr", overrun, 1);
        check_eq("ack_strobe_busy", busy, 0);

        // Reset mid-frame and mid-hold
        send_byte(8'hAA);
        send_byte(8'h10);
        send_byte(8'h02);
        send_byte(8'h34);
        pulse_reset();
        check_all_zero("rst_frame");
        send_frame(8'h66, 2, 32'h0000_BEEF);
        pulse_reset();
        check_all_zero("rst_hold");
        send_frame(8'h77, 2, 32'h0000_1234);
        ack_cmd();

        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/bt_cmd_parser.md
Name: bt_cmd_parser

Overview:
- Frame parser/sequencer behind the Bluetooth UART byte receiver.
- Consumes received bytes and assembles framed commands: SOF, code, length, 0..MAX_LEN payload bytes, XOR checksum.
- Presents each validated command to the application with a valid/ack handshake.
- Detects malformed frames, inter-byte timeouts and overruns.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- TIMEOUT_MS, 10, maximum gap between bytes inside a frame, in ms.
- MAX_LEN, 4, maximum payload bytes per frame (1..4).
- SOF, 8'hAA, start-of-frame byte.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from UART receiver.
- rx_ready  in  1  byte-available flag from receiver; each rising edge marks one new byte.
- cmd_valid  out  1  command frame available, held until accepted.
- cmd_ack  in  1  consumer accepts command when high with cmd_valid.
- cmd_code  out  8  command code.
- cmd_len  out  3  payload byte count, 0..MAX_LEN.
- cmd_payload  out  32  payload; byte i in bits [8i+7:8i], unused bytes zero.
- frame_err  out  1  one-cycle pulse: bad length or checksum.
- timeout_err  out  1  one-cycle pulse: inter-byte timeout.
- overrun  out  1  one-cycle pulse: byte dropped while a command is pending.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; rx_ready edge register 0; checksum, timeout counter and payload buffer 0.
- Byte strobe: strobe = rx_ready & ~rx_ready_d, where rx_ready_d is rx_ready registered. A level held high counts as one byte.
- States:
  - IDLE: strobe with rx_data==SOF → CODE. Other bytes are silently ignored.
  - CODE: strobe → latch code; chk = rx_data; → LEN.
  - LEN: strobe with rx_data > MAX_LEN → frame_err pulse, → IDLE. rx_data==0 → CHK. Otherwise latch len, clear payload, idx=0, → PAYLOAD. chk ^= rx_data in both accepted cases.
  - PAYLOAD: strobe → payload[idx] = rx_data; chk ^= rx_data; idx++. After byte len-1 → CHK.
  - CHK: strobe with rx_data==chk → HOLD, and cmd_valid rises the next cycle. Mismatch → frame_err pulse, → IDLE.
  - HOLD: cmd_valid=1. cmd_code, cmd_len and cmd_payload stay stable until the cycle cmd_valid & cmd_ack is seen. cmd_valid falls the following cycle, then → IDLE.
- HOLD byte handling: a strobe in HOLD drops the byte and pulses overrun. This applies even if the byte is SOF. The timeout counter does not run in HOLD.
- Timeout: counter runs in CODE, LEN, PAYLOAD and CHK, and is cleared on every strobe and on state entry.
  - When it reaches CLK_FREQ/1000*TIMEOUT_MS − 1: timeout_err pulse, → IDLE.
  - Counter is 32 bits wide.
- Simultaneous strobe and timeout terminal count: the strobe wins. The byte is processed and the counter is cleared.
- Simultaneous cmd_ack and strobe in HOLD: the ack is accepted and the byte is dropped with an overrun pulse.
- cmd_ack while cmd_valid=0 is ignored.
- Error pulses are mutually exclusive and last exactly one cycle.
- Reset mid-frame or mid-HOLD: the frame is discarded and the next cycle is in IDLE with all outputs 0.
- Latency: cmd_valid is asserted 1 cycle after the strobe of the checksum byte.

Test Plan:
- Valid frame: bytes AA,10,02,34,56,checksum 10^02^34^56=70 → cmd_valid with code 10, len 2, payload 32'h00005634. Held until cmd_ack, drops next cycle, no error pulses.
- Zero-length frame: AA,05,00,05 → cmd_valid with code 05, len 0, payload 0.
- Bad checksum: AA,10,01,FF,00 → one frame_err pulse, no cmd_valid. Following valid frame AA,01,00,01 is accepted.
- Length 5 > MAX_LEN: AA,22,05 → frame_err on the LEN byte. The next SOF restarts parsing.
- Timeout: TIMEOUT_MS=1, CLK_FREQ=100000. Send AA,10 then idle → timeout_err exactly 100 cycles after the last strobe, busy=0 afterwards.
- Overrun and reset: with cmd_valid held (no ack), send byte 11 → overrun pulse, outputs unchanged. Assert reset mid-frame → all outputs 0, back in IDLE.
